// File: rtl/ycbcr_pkg.sv
// Shared constants and helpers for the YCbCr 4:2:2 to 4:4:4 upsampler.
package ycbcr_pkg;

  // Input-to-output delay of data, syncs and data enable, in clk cycles
  localparam int unsigned YCBCR422_LATENCY = 3;

  // Component slot indices; slice a bus with [IDX*BPS +: BPS]
  localparam int unsigned COMP_Y    = 0;
  localparam int unsigned COMP_CB   = 1;
  localparam int unsigned COMP_CR   = 2;
  // Slot of the shared chroma sample on the 4:2:2 input bus
  localparam int unsigned COMP_C422 = 1;

  // Mid-scale chroma value, used where no real chroma sample exists
  function automatic int unsigned chroma_neutral(input int unsigned bps);
    return 32'd1 << (bps - 1);
  endfunction

endpackage

// File: rtl/ycbcr422_to_444_chroma_avg.sv
// Rounding average of two unsigned chroma samples: (a + b + 1) >> 1.
// The sum carries one extra bit, so full-scale inputs never wrap.
module chroma_avg #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] avg_o
);

  logic [Width:0] sum;

  // Widened sum with round-half-up, then drop the LSB
  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i} + (Width + 1)'(1);
    avg_o = Width'(sum >> 1);
  end

endmodule

// File: rtl/ycbcr422_to_444.sv
// YCbCr 4:2:2 -> 4:4:4 chroma upsampler, one pixel per clock, fixed 3-cycle latency.
// Even pixels carry Cb, odd pixels Cr; the phase restarts on each rising edge of de.
// Define CHROMA_INTERP_EN to average odd-pixel chroma with the next pair; otherwise
// odd pixels replicate their own pair's chroma.
module ycbcr422_to_444
  import ycbcr_pkg::*;
#(
  parameter int unsigned BIT_PER_SYMBLE = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*BIT_PER_SYMBLE-1:0] ycbcr_din,
  input  logic                        ycbcr_h_sync,
  input  logic                        ycbcr_v_sync,
  input  logic                        ycbcr_de,
  output logic [3*BIT_PER_SYMBLE-1:0] ycbcr_dout,
  output logic                        ycbcr_h_sync_o,
  output logic                        ycbcr_v_sync_o,
  output logic                        ycbcr_de_o
);

  localparam int unsigned BPS = BIT_PER_SYMBLE;
  localparam logic [BPS-1:0] NEUTRAL = BPS'(chroma_neutral(BPS));

  logic [BPS-1:0] in_y, in_c;
  logic           ph_in;

  // Stage 1 holds pixel n-1, stage 2 pixel n-2 (the one being emitted), c3 pixel n-3
  logic [BPS-1:0] y1_q, c1_q, y2_q, c2_q, c3_q;
  logic           de1_q, hs1_q, vs1_q, ph1_q;
  logic           de2_q, hs2_q, vs2_q, ph2_q;

  logic [BPS-1:0]   cb_d, cr_d;
  logic [3*BPS-1:0] dout_d, dout_q;
  logic             hs_q, vs_q, de_q;

  assign in_y = ycbcr_din[COMP_Y*BPS +: BPS];
  assign in_c = ycbcr_din[COMP_C422*BPS +: BPS];

  // Phase 0 on the first pixel after any de low (rising edge or after reset), else toggle
  assign ph_in = ycbcr_de & de1_q & ~ph1_q;

  // Input delay line with per-pixel phase tag and one extra chroma tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q  <= '0;
      c1_q  <= '0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      ph1_q <= 1'b0;
      y2_q  <= '0;
      c2_q  <= '0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      ph2_q <= 1'b0;
      c3_q  <= '0;
    end else begin
      y1_q  <= in_y;
      c1_q  <= in_c;
      de1_q <= ycbcr_de;
      hs1_q <= ycbcr_h_sync;
      vs1_q <= ycbcr_v_sync;
      ph1_q <= ph_in;
      y2_q  <= y1_q;
      c2_q  <= c1_q;
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      ph2_q <= ph1_q;
      c3_q  <= c2_q;
    end
  end

`ifdef CHROMA_INTERP_EN
  logic [BPS-1:0] cr_next, cb_avg, cr_avg;

  // Next pair's Cr is on the input bus now; a lone trailing Cb pairs with neutral Cr
  assign cr_next = ycbcr_de ? in_c : NEUTRAL;

  chroma_avg #(
    .Width (BPS)
  ) u_cb_avg (
    .a_i   (c3_q),
    .b_i   (c1_q),
    .avg_o (cb_avg)
  );

  chroma_avg #(
    .Width (BPS)
  ) u_cr_avg (
    .a_i   (c2_q),
    .b_i   (cr_next),
    .avg_o (cr_avg)
  );
`endif

  // Rebuild full chroma for the stage-2 pixel; blanking forces zero
  always_comb begin
    cb_d   = '0;
    cr_d   = '0;
    dout_d = '0;
    if (de2_q) begin
      if (!ph2_q) begin
        // Even pixel: own Cb, Cr from the following pixel if the line continues
        cb_d = c2_q;
        cr_d = de1_q ? c1_q : NEUTRAL;
      end else begin
        // Odd pixel: Cb from the previous pixel, own Cr
        cb_d = c3_q;
        cr_d = c2_q;
`ifdef CHROMA_INTERP_EN
        // A following pair exists only if the line continues past this pixel
        if (de1_q) begin
          cb_d = cb_avg;
          cr_d = cr_avg;
        end
`endif
      end
      dout_d[COMP_Y*BPS +: BPS]  = y2_q;
      dout_d[COMP_CB*BPS +: BPS] = cb_d;
      dout_d[COMP_CR*BPS +: BPS] = cr_d;
    end
  end

  // Output stage: third pipeline register for data and timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      hs_q   <= hs2_q;
      vs_q   <= vs2_q;
      de_q   <= de2_q;
    end
  end

  assign ycbcr_dout     = dout_q;
  assign ycbcr_h_sync_o = hs_q;
  assign ycbcr_v_sync_o = vs_q;
  assign ycbcr_de_o     = de_q;

endmodule

// File: tb/tb_ycbcr422_to_444.sv
// Scoreboard bench for ycbcr422_to_444: a driver pushes expected outputs computed from
// a line-level model, a monitor pops and compares one entry per output cycle.
module tb_ycbcr422_to_444;
  import ycbcr_pkg::*;

  localparam int BPS = 8;
  localparam int MAXN = 2048;
`ifdef CHROMA_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*BPS-1:0] ycbcr_din;
  logic           ycbcr_h_sync, ycbcr_v_sync, ycbcr_de;
  logic [3*BPS-1:0] ycbcr_dout;
  logic           ycbcr_h_sync_o, ycbcr_v_sync_o, ycbcr_de_o;

  ycbcr422_to_444 #(
    .BIT_PER_SYMBLE (BPS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ycbcr_din      (ycbcr_din),
    .ycbcr_h_sync   (ycbcr_h_sync),
    .ycbcr_v_sync   (ycbcr_v_sync),
    .ycbcr_de       (ycbcr_de),
    .ycbcr_dout     (ycbcr_dout),
    .ycbcr_h_sync_o (ycbcr_h_sync_o),
    .ycbcr_v_sync_o (ycbcr_v_sync_o),
    .ycbcr_de_o     (ycbcr_de_o)
  );

  always #5 clk = ~clk;

  int unsigned pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  typedef struct {
    int unsigned    due;
    logic [3*BPS-1:0] dout;
    logic           hs;
    logic           vs;
    logic           de;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // Current segment of stimulus, one entry per clock
  logic           sde[MAXN];
  logic           shs[MAXN];
  logic           svs[MAXN];
  logic [BPS-1:0] sy[MAXN];
  logic [BPS-1:0] sc[MAXN];
  int             sn;

  // Expected output for segment index i, derived from line/pair structure
  function automatic exp_t model(input int i);
    exp_t r;
    int s, e, p, k, cb, cr, cbn, crn, neutral;
    neutral = int'(chroma_neutral(BPS));
    r.due = 0;
    r.hs  = shs[i];
    r.vs  = svs[i];
    r.de  = sde[i];
    r.dout = '0;
    if (!sde[i]) return r;
    s = i;
    while (s > 0 && sde[s-1]) s--;
    e = i;
    while (e < sn && sde[e]) e++;
    p  = i - s;
    k  = p / 2;
    cb = int'(sc[s + 2*k]);
    cr = (s + 2*k + 1 < e) ? int'(sc[s + 2*k + 1]) : neutral;
    if (INTERP && (p % 2 == 1) && (s + 2*k + 2 < e)) begin
      cbn = int'(sc[s + 2*k + 2]);
      crn = (s + 2*k + 3 < e) ? int'(sc[s + 2*k + 3]) : neutral;
      cb  = (cb + cbn + 1) / 2;
      cr  = (cr + crn + 1) / 2;
    end
    r.dout = {BPS'(cr), BPS'(cb), sy[i]};
    return r;
  endfunction

  task automatic push_zero(input int unsigned due);
    exp_t r;
    r.due = due;
    r.dout = '0;
    r.hs = 1'b0;
    r.vs = 1'b0;
    r.de = 1'b0;
    sbq.push_back(r);
  endtask

  // Fill a line: pre blanking, act active pixels, post blanking (post >= 2)
  task automatic build_line(input int act, input int pre, input int post, input bit vpulse);
    sn = pre + act + post;
    for (int i = 0; i < sn; i++) begin
      sde[i] = (i >= pre) && (i < pre + act);
      shs[i] = (i < pre / 2);
      svs[i] = vpulse && (i < pre);
      sy[i]  = BPS'($urandom);
      sc[i]  = BPS'($urandom);
    end
  endtask

  task automatic drive(input int i);
    exp_t r;
    @(posedge clk);
    #1;
    ycbcr_de     = sde[i];
    ycbcr_h_sync = shs[i];
    ycbcr_v_sync = svs[i];
    ycbcr_din    = {sc[i], sy[i]};
    r = model(i);
    r.due = pcnt + YCBCR422_LATENCY;
    sbq.push_back(r);
  endtask

  task automatic run_seg(input int ndrive);
    for (int i = 0; i < ndrive; i++) drive(i);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (ycbcr_dout !== '0 || ycbcr_de_o !== 1'b0 || ycbcr_h_sync_o !== 1'b0 ||
        ycbcr_v_sync_o !== 1'b0) begin
      bad++;
      $display("FAIL %s: got dout=%h hs=%b vs=%b de=%b, need all zero", name, ycbcr_dout,
               ycbcr_h_sync_o, ycbcr_v_sync_o, ycbcr_de_o);
    end
  endtask

  // Asynchronous reset for two cycles; pipeline refills with idle input
  task automatic do_reset();
    int unsigned p;
    @(posedge clk);
    #1;
    p = pcnt;
    while (sbq.size() > 0 && sbq[$].due >= p) void'(sbq.pop_back());
    rst_n        = 1'b0;
    ycbcr_de     = 1'b0;
    ycbcr_h_sync = 1'b0;
    ycbcr_v_sync = 1'b0;
    ycbcr_din    = '0;
    #1;
    check_zero("async_clear");
    for (int unsigned d = p; d <= p + 5; d++) push_zero(d);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare one expected entry whenever its due cycle arrives
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due < pcnt) begin
        e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL missed_output: due=%0d now=%0d", e.due, pcnt);
      end
      if (sbq.size() > 0 && sbq[0].due == pcnt) begin
        e = sbq.pop_front();
        total++;
        if (ycbcr_dout !== e.dout || ycbcr_h_sync_o !== e.hs || ycbcr_v_sync_o !== e.vs ||
            ycbcr_de_o !== e.de) begin
          bad++;
          $display("FAIL pixel_out cyc=%0d: got dout=%h hs=%b vs=%b de=%b, need dout=%h hs=%b vs=%b de=%b",
                   pcnt, ycbcr_dout, ycbcr_h_sync_o, ycbcr_v_sync_o, ycbcr_de_o,
                   e.dout, e.hs, e.vs, e.de);
        end
      end
    end
  end

  initial begin
    int unsigned p;
    int wait_cnt;
    rst_n        = 1'b0;
    ycbcr_de     = 1'b0;
    ycbcr_h_sync = 1'b0;
    ycbcr_v_sync = 1'b0;
    ycbcr_din    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    p = pcnt;
    rst_n = 1'b1;
    for (int unsigned d = p + 1; d <= p + 3; d++) push_zero(d);

    // Four-pixel line with known values
    build_line(4, 3, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      sy[3+i] = BPS'(i + 1);
      sc[3+i] = BPS'(16 * (i + 1));
    end
    run_seg(sn);

    // Rounding case: Cb 0x01 then 0x02
    build_line(4, 2, 3, 1'b0);
    sc[2] = 8'h01; sc[3] = 8'h55; sc[4] = 8'h02; sc[5] = 8'h66;
    run_seg(sn);

    // Odd-length and single-pixel lines
    build_line(3, 2, 3, 1'b0);
    run_seg(sn);
    build_line(1, 2, 3, 1'b0);
    run_seg(sn);

    // Full-scale chroma, then all-zero components
    build_line(8, 2, 3, 1'b0);
    for (int i = 0; i < sn; i++) sc[i] = '1;
    run_seg(sn);
    build_line(6, 2, 3, 1'b0);
    for (int i = 0; i < sn; i++) begin
      sc[i] = '0;
      sy[i] = '0;
    end
    run_seg(sn);

    // Short random lines with gaps, including back-to-back rising edges
    for (int n = 0; n < 30; n++) begin
      build_line(int'($urandom_range(1, 9)), int'($urandom_range(1, 3)),
                 int'($urandom_range(2, 4)), 1'($urandom_range(0, 1)));
      run_seg(sn);
    end

    // Full-width lines: 1280 active, 370 blank, v_sync on the first
    for (int n = 0; n < 3; n++) begin
      build_line(1280, 200, 170, n == 0);
      run_seg(sn);
    end

    // Reset during pixel 7 of a 16-pixel line, then a clean line
    build_line(16, 2, 3, 1'b0);
    run_seg(2 + 8);
    do_reset();
    build_line(16, 2, 3, 1'b1);
    run_seg(sn);
    build_line(5, 2, 3, 1'b0);
    run_seg(sn);

    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending entries, need 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
